// File: rtl/car_presence_if.sv
// Presence-conditioner bus: raw loop level in, conditioned request and
// maintenance counters out.
interface car_presence_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             X;
    logic             lockout;
    logic             car_pulse;
    logic [CNT_W-1:0] car_count;

    modport master (
        output sensor_raw,
        input  X,
        input  lockout,
        input  car_pulse,
        input  car_count
    );

    modport slave (
        input  sensor_raw,
        output X,
        output lockout,
        output car_pulse,
        output car_count
    );
endinterface

// File: rtl/car_presence_conditioner.sv
// Turns the raw country-road loop level into a debounced, gap-extended,
// time-capped presence request X and counts vehicle arrivals.
//
// state    | meaning
// IDLE     | no vehicle, X low, waiting for debounced presence
// ON       | vehicle present, X high
// HOLD     | presence dropped, X held high to bridge short gaps
// LOCKOUT  | X forced low after a continuous request hit the cap
module car_presence_conditioner #(
    parameter int DEB_CYCLES     = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int MAX_ON         = 16,
    parameter int LOCKOUT_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic          clock,
    input  logic          clear,
    car_presence_if.slave bus
);

    localparam int MC_W   = $clog2(DEB_CYCLES + 1);
    localparam int ON_W   = $clog2(MAX_ON);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int LK_W   = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [MC_W-1:0]   MC_LAST   = MC_W'(DEB_CYCLES - 1);
    localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MAX_ON - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LK_W-1:0]   LK_LAST   = LK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ON      = 2'd1,
        ST_HOLD    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             det_q, det_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    state_t           state_q, state_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LK_W-1:0]  lk_cnt_q, lk_cnt_d;
    logic             car_pulse_q, car_pulse_d;
    logic [CNT_W-1:0] car_count_q, car_count_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            det_q       <= 1'b0;
            mc_q        <= '0;
            state_q     <= ST_IDLE;
            on_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            lk_cnt_q    <= '0;
            car_pulse_q <= 1'b0;
            car_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            det_q       <= det_d;
            mc_q        <= mc_d;
            state_q     <= state_d;
            on_cnt_q    <= on_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            lk_cnt_q    <= lk_cnt_d;
            car_pulse_q <= car_pulse_d;
            car_count_q <= car_count_d;
        end
    end

    // Two-flop synchroniser, then a level accepted only after DEB_CYCLES
    // consecutive disagreeing samples.
    always_comb begin
        s1_d  = bus.sensor_raw;
        s2_d  = s1_q;
        det_d = det_q;
        mc_d  = '0;
        if (s2_q != det_q) begin
            if (mc_q == MC_LAST) begin
                det_d = ~det_q;
            end else begin
                mc_d = mc_q + MC_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        on_cnt_d    = on_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        lk_cnt_d    = lk_cnt_q;
        car_pulse_d = 1'b0;
        car_count_d = car_count_q;
        case (state_q)
            ST_IDLE: begin
                if (det_q) begin
                    state_d     = ST_ON;
                    on_cnt_d    = '0;
                    car_pulse_d = 1'b1;
                    if (car_count_q != {CNT_W{1'b1}}) begin
                        car_count_d = car_count_q + CNT_W'(1);
                    end
                end
            end
            ST_ON: begin
                on_cnt_d = on_cnt_q + ON_W'(1);
                if (on_cnt_q == ON_LAST) begin
                    state_d  = ST_LOCKOUT;
                    lk_cnt_d = '0;
                end else if (!det_q) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                // on_cnt keeps running so a bridged gap still counts toward the cap
                on_cnt_d   = on_cnt_q + ON_W'(1);
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (on_cnt_q == ON_LAST) begin
                    state_d  = ST_LOCKOUT;
                    lk_cnt_d = '0;
                end else if (det_q) begin
                    state_d = ST_ON;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                lk_cnt_d = lk_cnt_q + LK_W'(1);
                if (lk_cnt_q == LK_LAST) begin
                    state_d  = det_q ? ST_ON : ST_IDLE;
                    on_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.X         = (state_q == ST_ON) || (state_q == ST_HOLD);
    assign bus.lockout   = (state_q == ST_LOCKOUT);
    assign bus.car_pulse = car_pulse_q;
    assign bus.car_count = car_count_q;

endmodule

// File: doc/car_presence_conditioner.md
Name: car_presence_conditioner

Overview:
- Upstream stage of the intersection signal controller: converts the raw country-road vehicle-loop input into the clean presence request X that the controller consumes.
- Synchronises, debounces, extends short gaps between vehicles and caps continuous requests so the highway is never starved.
- Also counts vehicle arrivals for the maintenance interface.

Parameters:
DEB_CYCLES, 3, consecutive stable synchronised samples required to accept a level change (>=1)
HOLD_CYCLES, 4, cycles X stays high after debounced presence drops (gap extension, >=1)
MAX_ON, 16, maximum consecutive cycles X may be high before forced lockout (>=2)
LOCKOUT_CYCLES, 8, cycles X is forced low after a cap hit (>=1)
CNT_W, 8, width of car_count

Ports:
clock  input  1  system clock; all state changes on rising edge
clear  input  1  synchronous active-high reset
sensor_raw  input  1  raw loop-detector level, asynchronous to clock
X  output  1  conditioned presence request to the signal controller
lockout  output  1  high while a cap-induced lockout is in progress
car_pulse  output  1  one-cycle pulse per accepted new arrival
car_count  output  CNT_W  saturating count of accepted arrivals

Behaviour:
- Reset: clear sampled high at a rising edge sets all state to zero. After that edge: X=0, lockout=0, car_pulse=0, car_count=0, FSM=IDLE, sync flops=0, det=0. clear has priority over every other event, including mid-ON, mid-HOLD or mid-LOCKOUT.
- Synchroniser: two flops, s1 <= sensor_raw and s2 <= s1. Only s2 is used downstream.
- Debounce:
  - Mismatch counter mc increments on each edge where s2 != det. It resets to 0 on any edge where s2 == det.
  - det toggles, and mc clears, on the edge where mc == DEB_CYCLES-1 and s2 != det.
  - Pulses or gaps shorter than DEB_CYCLES cycles at s2 are rejected.
- FSM: four states, IDLE, ON, HOLD, LOCKOUT. All outputs are decoded from registered state, Moore style.
  - IDLE: X=0. On det=1, go to ON. On that same edge, on_cnt=0, car_pulse=1 for the following cycle, and car_count increments, saturating at all-ones.
  - ON: X=1, on_cnt increments each edge.
    - If on_cnt == MAX_ON-1, go to LOCKOUT (highest priority).
    - Else if det=0, go to HOLD with hold_cnt=0.
  - HOLD: X=1, on_cnt keeps incrementing and hold_cnt increments.
    - Cap check first: on_cnt == MAX_ON-1 sends the FSM to LOCKOUT.
    - Else det=1 returns to ON. This is the same occupancy: no pulse, no count.
    - Else hold_cnt == HOLD_CYCLES-1 goes to IDLE.
  - LOCKOUT: X=0, lockout=1, lk_cnt increments. On lk_cnt == LOCKOUT_CYCLES-1:
    - if det=1, go to ON with on_cnt=0, no pulse and no count;
    - if det=0, go to IDLE.
- Timing consequences:
  - X is high for at most MAX_ON consecutive cycles.
  - A lockout lasts exactly LOCKOUT_CYCLES cycles.
  - HOLD lasts HOLD_CYCLES cycles if uninterrupted.
- Latency: take edge 0 as the first edge sampling sensor_raw=1.
  - s2=1 after edge 1, det=1 after edge DEB_CYCLES+1, X=1 after edge DEB_CYCLES+2 (edge 5 for the defaults).
  - The falling path has the same latency to HOLD, plus HOLD_CYCLES before X drops.
- Saturation: car_count holds at 2^CNT_W-1. car_pulse still fires on each arrival.
- car_pulse is exactly one cycle wide and is never asserted in the ON state reached from HOLD or from LOCKOUT.

Test Plan:
- Reset and clean arrival: assert clear for 2 cycles, then hold sensor_raw=1. Required: X=0 through edge 4, X=1 after edge 5, car_pulse high for exactly 1 cycle, car_count=1.
- Glitch rejection: sensor_raw high for 2 cycles, then low. Required: X stays 0, car_count=0, car_pulse never asserted.
- Gap bridging: establish presence, drop sensor_raw for 3 cycles, then raise it again. Required: X never falls, car_count remains 1. Then drop sensor_raw permanently: X falls exactly 4 cycles after the FSM enters HOLD.
- Cap and lockout: hold sensor_raw=1 continuously.
  - Required: X high for exactly 16 cycles, then X=0 and lockout=1 for exactly 8 cycles.
  - X then returns high with no new car_pulse; car_count stays 1.
- Saturation: set CNT_W=2 and generate 5 separated arrivals. Required: car_count sequence 1,2,3,3,3, and 5 car_pulses.
- Reset mid-operation: assert clear during ON, and again during LOCKOUT. Required: after the clear edge, X=0, lockout=0, car_count=0, FSM=IDLE. Presence must then be re-qualified with the full DEB_CYCLES+2 latency.
